// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: gear encoding, default fixed-point formats and
// signed clamp helpers used by the loop filter, DCO and phase-detector blocks.
package adpll_pkg;

    typedef enum logic {
        GEAR_ACQ = 1'b0,
        GEAR_TRK = 1'b1
    } gear_e;

    localparam int DEF_ERROR_WIDTH   = 8;
    localparam int DEF_DCO_CC_WIDTH  = 9;
    localparam int DEF_ACC_WIDTH     = 16;
    localparam int DEF_KP_FRAC_WIDTH = 2;
    localparam int DEF_KI_FRAC_WIDTH = 5;

    function automatic logic signed [31:0] sat_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

    // Clamp a sign-extended value into the range of a w-bit signed number.
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] x, input int w);
        if (x > sat_max(w)) return sat_max(w);
        if (x < sat_min(w)) return sat_min(w);
        return x;
    endfunction

    function automatic logic sat_hit(input logic signed [31:0] x, input int w);
        return (x > sat_max(w)) || (x < sat_min(w));
    endfunction

endpackage

// File: rtl/lf_lock_detect.sv
// Lock detector for the loop filter: error-magnitude thresholds, consecutive
// in-lock counter and the ACQ/TRACK gear state machine.
module lf_lock_detect
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH   = DEF_ERROR_WIDTH,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8
) (
    input  logic                   gen_clk_i,
    input  logic                   reset_i,
    input  logic                   error_valid_i,
    input  logic [ERROR_WIDTH-1:0] error_i,
    input  logic                   sample_vld_i,
    input  logic                   force_acq_i,
    output logic                   gear_o,
    output logic                   gear_next_o
);
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    logic [ERROR_WIDTH-1:0] err_mag;
    logic                   in_lock_q, in_lock_d;
    logic                   unlock_q, unlock_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    gear_e                  gear_q, gear_d;

    always_comb begin
        // Unsigned magnitude: the most negative code maps to the largest value.
        err_mag   = error_i[ERROR_WIDTH-1] ? (~error_i + ERROR_WIDTH'(1)) : error_i;
        in_lock_d = in_lock_q;
        unlock_d  = unlock_q;
        if (error_valid_i) begin
            in_lock_d = (32'(err_mag) <= LOCK_THRESH);
            unlock_d  = (32'(err_mag) > UNLOCK_THRESH);
        end

        gear_d = gear_q;
        cnt_d  = cnt_q;
        if (force_acq_i) begin
            gear_d = GEAR_ACQ;
            cnt_d  = '0;
        end else if (sample_vld_i) begin
            if (gear_q == GEAR_ACQ) begin
                if (!in_lock_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_COUNT - 1)) begin
                    gear_d = GEAR_TRK;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (unlock_q) begin
                gear_d = GEAR_ACQ;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            in_lock_q <= 1'b0;
            unlock_q  <= 1'b0;
            cnt_q     <= '0;
            gear_q    <= GEAR_ACQ;
        end else begin
            in_lock_q <= in_lock_d;
            unlock_q  <= unlock_d;
            cnt_q     <= cnt_d;
            gear_q    <= gear_d;
        end
    end

    assign gear_o      = gear_q;
    assign gear_next_o = gear_d;

endmodule

// File: rtl/loop_filter_geared.sv
// Geared PI loop filter: signed phase error in, saturated DCO control code out,
// two pipeline stages with the gain set chosen by the lock detector.
module loop_filter_geared
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH   = DEF_ERROR_WIDTH,
    parameter int DCO_CC_WIDTH  = DEF_DCO_CC_WIDTH,
    parameter int KP_WIDTH      = 4,
    parameter int KP_FRAC_WIDTH = DEF_KP_FRAC_WIDTH,
    parameter int KI_WIDTH      = 6,
    parameter int KI_FRAC_WIDTH = DEF_KI_FRAC_WIDTH,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8
) (
    input  logic                    gen_clk_i,
    input  logic                    reset_i,
    input  logic                    error_valid_i,
    input  logic [ERROR_WIDTH-1:0]  error_i,
    input  logic [KP_WIDTH-1:0]     kp_acq_i,
    input  logic [KI_WIDTH-1:0]     ki_acq_i,
    input  logic [KP_WIDTH-1:0]     kp_trk_i,
    input  logic [KI_WIDTH-1:0]     ki_trk_i,
    input  logic                    freeze_i,
    input  logic                    force_acq_i,
    output logic [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                    dco_cc_valid_o,
    output logic                    gear_o,
    output logic                    sat_o
);
    localparam int SHIFT  = KI_FRAC_WIDTH - KP_FRAC_WIDTH;
    localparam int P_W    = ERROR_WIDTH + KP_WIDTH + 1;
    localparam int I_W    = ERROR_WIDTH + KI_WIDTH + 1;
    localparam int ACCS_W = ACC_WIDTH + 1;
    localparam int PS_W   = P_W + SHIFT;
    localparam int SUM_W  = ((PS_W > ACC_WIDTH) ? PS_W : ACC_WIDTH) + 2;
    localparam int HALF   = 1 << (KI_FRAC_WIDTH - 1);

    logic [1:0]                     vld_pipe_q, vld_pipe_d;
    logic signed [ERROR_WIDTH-1:0]  err_q, err_d;
    logic [KP_WIDTH-1:0]            kp_q, kp_d;
    logic [KI_WIDTH-1:0]            ki_q, ki_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [DCO_CC_WIDTH-1:0] dco_cc_q, dco_cc_d;
    logic                           sat_q, sat_d;
    logic                           gear_next;

    logic signed [P_W-1:0]          p_prod;
    logic signed [I_W-1:0]          i_prod;
    logic signed [ACCS_W-1:0]       acc_sum;
    logic signed [ACC_WIDTH-1:0]    acc_new;
    logic signed [SUM_W-1:0]        sum, code_full;
    logic                           acc_clamp;

    lf_lock_detect #(
        .ERROR_WIDTH   (ERROR_WIDTH),
        .LOCK_THRESH   (LOCK_THRESH),
        .LOCK_COUNT    (LOCK_COUNT),
        .UNLOCK_THRESH (UNLOCK_THRESH)
    ) u_lock (
        .gen_clk_i     (gen_clk_i),
        .reset_i       (reset_i),
        .error_valid_i (error_valid_i),
        .error_i       (error_i),
        .sample_vld_i  (vld_pipe_q[0]),
        .force_acq_i   (force_acq_i),
        .gear_o        (gear_o),
        .gear_next_o   (gear_next)
    );

    // Gains follow the gear as updated on this edge, so a gear change
    // reaches the very next sample even when samples arrive back-to-back.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[0], error_valid_i};
        err_d      = err_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        if (error_valid_i) begin
            err_d = error_i;
            kp_d  = (gear_next == GEAR_TRK) ? kp_trk_i : kp_acq_i;
            ki_d  = (gear_next == GEAR_TRK) ? ki_trk_i : ki_acq_i;
        end
    end

    always_comb begin
        p_prod    = P_W'(err_q) * P_W'($signed({1'b0, kp_q}));
        i_prod    = I_W'(err_q) * I_W'($signed({1'b0, ki_q}));
        acc_sum   = ACCS_W'(acc_q) + ACCS_W'(i_prod);
        acc_new   = freeze_i ? acc_q : ACC_WIDTH'(sat_clamp(32'(acc_sum), ACC_WIDTH));
        acc_clamp = !freeze_i && sat_hit(32'(acc_sum), ACC_WIDTH);
        sum       = (SUM_W'(p_prod) <<< SHIFT) + SUM_W'(acc_new);
        code_full = (sum + SUM_W'(HALF)) >>> KI_FRAC_WIDTH;

        acc_d    = acc_q;
        dco_cc_d = dco_cc_q;
        sat_d    = sat_q;
        if (vld_pipe_q[0]) begin
            acc_d    = acc_new;
            dco_cc_d = DCO_CC_WIDTH'(sat_clamp(32'(code_full), DCO_CC_WIDTH));
            sat_d    = acc_clamp || sat_hit(32'(code_full), DCO_CC_WIDTH);
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            vld_pipe_q <= '0;
            err_q      <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            acc_q      <= '0;
            dco_cc_q   <= '0;
            sat_q      <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            err_q      <= err_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            acc_q      <= acc_d;
            dco_cc_q   <= dco_cc_d;
            sat_q      <= sat_d;
        end
    end

    assign dco_cc_o       = dco_cc_q;
    assign dco_cc_valid_o = vld_pipe_q[1];
    assign sat_o          = sat_q;

endmodule

// File: tb/tb_loop_filter_geared.sv
// Bench for loop_filter_geared: directed scenarios plus randomized traffic,
// every cycle compared against an integer-arithmetic model of the filter.
module tb_loop_filter_geared;

    logic       gen_clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       error_valid_i = 1'b0;
    logic [7:0] error_i = '0;
    logic [3:0] kp_acq_i = '0, kp_trk_i = '0;
    logic [5:0] ki_acq_i = '0, ki_trk_i = '0;
    logic       freeze_i = 1'b0, force_acq_i = 1'b0;
    logic [8:0] dco_cc_o;
    logic       dco_cc_valid_o, gear_o, sat_o;

    always #5 gen_clk_i = ~gen_clk_i;

    loop_filter_geared dut (
        .gen_clk_i      (gen_clk_i),
        .reset_i        (reset_i),
        .error_valid_i  (error_valid_i),
        .error_i        (error_i),
        .kp_acq_i       (kp_acq_i),
        .ki_acq_i       (ki_acq_i),
        .kp_trk_i       (kp_trk_i),
        .ki_trk_i       (ki_trk_i),
        .freeze_i       (freeze_i),
        .force_acq_i    (force_acq_i),
        .dco_cc_o       (dco_cc_o),
        .dco_cc_valid_o (dco_cc_valid_o),
        .gear_o         (gear_o),
        .sat_o          (sat_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, in plain integers (accumulator in 1/32 units).
    int m_acc = 0, m_gear = 0, m_cnt = 0, m_dco = 0, m_sat = 0, m_vld = 0;
    bit pend = 0;
    int pend_e, pend_kp, pend_ki;
    int st_dco[$];
    int st_gear[$];
    int st_sat[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_edge();
        int p, a, s, o;
        if (reset_i) begin
            m_acc = 0; m_gear = 0; m_cnt = 0; m_dco = 0; m_sat = 0; m_vld = 0; pend = 0;
            return;
        end
        m_vld = pend;
        if (pend) begin
            m_sat = 0;
            p = pend_e * pend_kp;                    // Kp has 2 fraction bits
            if (!freeze_i) begin
                a = m_acc + pend_e * pend_ki;        // Ki has 5 fraction bits
                if (a > 32767) begin a = 32767; m_sat = 1; end
                if (a < -32768) begin a = -32768; m_sat = 1; end
                m_acc = a;
            end
            s = p * 8 + m_acc;
            o = (s + 16) >>> 5;
            if (o > 255) begin o = 255; m_sat = 1; end
            if (o < -256) begin o = -256; m_sat = 1; end
            m_dco = o;
            if (m_gear == 0) begin
                if (iabs(pend_e) <= 2) begin
                    m_cnt++;
                    if (m_cnt == 16) begin m_gear = 1; m_cnt = 0; end
                end else m_cnt = 0;
            end else if (iabs(pend_e) > 8) begin
                m_gear = 0; m_cnt = 0;
            end
        end
        if (force_acq_i) begin m_gear = 0; m_cnt = 0; end
        pend = error_valid_i;
        if (error_valid_i) begin
            pend_e  = $signed(error_i);
            pend_kp = m_gear ? int'(kp_trk_i) : int'(kp_acq_i);
            pend_ki = m_gear ? int'(ki_trk_i) : int'(ki_acq_i);
        end
    endtask

    task automatic tick();
        @(posedge gen_clk_i);
        model_edge();
        #1;
        chk("strobe", 32'(dco_cc_valid_o), m_vld);
        chk("dco_cc", 32'($signed(dco_cc_o)), m_dco);
        chk("gear", 32'(gear_o), m_gear);
        chk("sat", 32'(sat_o), m_sat);
        if (dco_cc_valid_o === 1'b1) begin
            st_dco.push_back(int'($signed(dco_cc_o)));
            st_gear.push_back(int'(gear_o));
            st_sat.push_back(int'(sat_o));
        end
    endtask

    task automatic clear_log();
        st_dco.delete(); st_gear.delete(); st_sat.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1; error_valid_i = 1'b0; freeze_i = 1'b0; force_acq_i = 1'b0;
        tick();
        reset_i = 1'b0;
        clear_log();
    endtask

    task automatic send(input int e);
        error_valid_i = 1'b1; error_i = 8'(e);
        tick();
    endtask

    task automatic idle(input int n);
        error_valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic set_gains(input int kpa, input int kia, input int kpt, input int kit);
        kp_acq_i = 4'(kpa); ki_acq_i = 6'(kia); kp_trk_i = 4'(kpt); ki_trk_i = 6'(kit);
    endtask

    initial begin
        int calm;
        // 1. reset held two cycles, then idle
        reset_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0;
        clear_log();
        idle(3);
        chk("rst_dco", 32'($signed(dco_cc_o)), 0);
        chk("rst_gear", 32'(gear_o), 0);
        chk("rst_nstrobe", st_dco.size(), 0);

        // 2. step response, back-to-back
        set_gains(4, 16, 4, 16);
        for (int i = 0; i < 4; i++) send(4);
        idle(3);
        chk("step_n", st_dco.size(), 4);
        for (int i = 0; i < 4; i++) chk("step_val", st_dco[i], 6 + 2 * i);

        // 3. rounding, then the same with the integrator frozen
        do_reset();
        set_gains(0, 1, 0, 1);
        for (int i = 0; i < 16; i++) send(1);
        idle(3);
        chk("rnd_15", st_dco[14], 0);
        chk("rnd_16", st_dco[15], 1);
        do_reset();
        freeze_i = 1'b1;
        for (int i = 0; i < 16; i++) send(1);
        idle(3);
        chk("frz_16", st_dco[15], 0);
        freeze_i = 1'b0;

        // 4. saturation and unwinding
        do_reset();
        set_gains(15, 63, 15, 63);
        for (int i = 0; i < 8; i++) send(127);
        for (int i = 0; i < 4; i++) send(-128);
        idle(3);
        chk("sat_hi_val", st_dco[7], 255);
        chk("sat_hi_flag", st_sat[7], 1);
        chk("unwind_1", st_dco[8], 255);
        chk("unwind_2", st_dco[9], 40);
        chk("unwind_2_sat", st_sat[9], 0);

        // 5. gear shifting with back-to-back samples
        do_reset();
        set_gains(4, 16, 2, 8);
        for (int i = 0; i < 16; i++) send(0);
        send(4); send(8); send(9);
        idle(3);
        chk("gear_15", st_gear[14], 0);
        chk("gear_16", st_gear[15], 1);
        chk("trk_gain", st_dco[16], 3);
        chk("stay_trk_8", st_gear[17], 1);
        chk("unlock_9", st_gear[18], 0);

        // 6. mid-stream reset discards in-flight samples; force without valid
        do_reset();
        set_gains(4, 16, 4, 16);
        send(4); send(4); send(4);
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        clear_log();
        idle(3);
        chk("midrst_n", st_dco.size(), 0);
        send(4);
        idle(3);
        chk("midrst_acc0", st_dco[0], 6);
        for (int i = 0; i < 16; i++) send(0);
        idle(3);
        chk("pre_force", 32'(gear_o), 1);
        force_acq_i = 1'b1; tick(); force_acq_i = 1'b0;
        chk("force_gear", 32'(gear_o), 0);
        idle(2);

        // 7. randomized traffic alternating calm and wild phases
        calm = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) calm = !calm;
            if ($urandom_range(0, 99) < 3)
                set_gains($urandom_range(0, 15), $urandom_range(0, 63),
                          $urandom_range(0, 15), $urandom_range(0, 63));
            error_valid_i = ($urandom_range(0, 9) < 8);
            if (calm != 0 && $urandom_range(0, 99) < 97) error_i = 8'($urandom_range(0, 4) - 2);
            else if (calm != 0) error_i = 8'($urandom_range(0, 24) - 12);
            else error_i = 8'($urandom);
            freeze_i    = ($urandom_range(0, 9) == 0);
            force_acq_i = ($urandom_range(0, 99) == 0);
            reset_i     = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset_i = 1'b0; force_acq_i = 1'b0; freeze_i = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
